// File: rtl/ofs_plat_ccip_rd_to_avmm_split_bridge.sv
// CCI-P-style read request channel to Avalon-MM read bridge. Buffers requests, splits them into
// aligned bursts under an outstanding-line credit budget and rebuilds per-line responses.
module ofs_plat_ccip_rd_to_avmm_split_bridge #(
  parameter int unsigned ADDR_WIDTH            = 42,
  parameter int unsigned DATA_WIDTH            = 512,
  parameter int unsigned MDATA_WIDTH           = 16,
  parameter int unsigned MAX_REQ_LINES         = 4,
  parameter int unsigned MAX_AVMM_BURST        = 2,
  parameter int unsigned IN_FIFO_DEPTH         = 8,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 4,
  parameter int unsigned MAX_ACTIVE_LINES      = 64,
  localparam int unsigned LEN_W   = $clog2(MAX_REQ_LINES),
  localparam int unsigned BURST_W = $clog2(MAX_AVMM_BURST) + 1,
  localparam int unsigned ACT_W   = $clog2(MAX_ACTIVE_LINES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [LEN_W-1:0]       i_req_len,
  input  logic [MDATA_WIDTH-1:0] i_req_mdata,
  output logic                   o_req_almost_full,
  output logic                   o_avmm_read,
  output logic [ADDR_WIDTH-1:0]  o_avmm_address,
  output logic [BURST_W-1:0]     o_avmm_burstcount,
  input  logic                   i_avmm_waitrequest,
  input  logic [DATA_WIDTH-1:0]  i_avmm_readdata,
  input  logic                   i_avmm_readdatavalid,
  output logic                   o_rsp_valid,
  output logic [DATA_WIDTH-1:0]  o_rsp_data,
  output logic [LEN_W-1:0]       o_rsp_cl_num,
  output logic [MDATA_WIDTH-1:0] o_rsp_mdata,
  output logic                   o_rsp_last,
  output logic [ACT_W-1:0]       o_active_lines,
  output logic                   o_err_overflow,
  output logic                   o_err_underflow
);

  localparam int unsigned LINES_W  = LEN_W + 1;
  localparam int unsigned BUF_PW   = (IN_FIFO_DEPTH > 1) ? $clog2(IN_FIFO_DEPTH) : 1;
  localparam int unsigned BUF_CW   = $clog2(IN_FIFO_DEPTH + 1);
  localparam int unsigned TRK_PW   = (MAX_ACTIVE_LINES > 1) ? $clog2(MAX_ACTIVE_LINES) : 1;
  localparam int unsigned AF_LEVEL = IN_FIFO_DEPTH - ALMOST_FULL_THRESHOLD;

  typedef enum logic [0:0] {StIdle, StIssue} state_t;

  // ---------------- request buffer ----------------
  logic [ADDR_WIDTH-1:0]  r_buf_addr  [IN_FIFO_DEPTH];
  logic [LEN_W-1:0]       r_buf_len   [IN_FIFO_DEPTH];
  logic [MDATA_WIDTH-1:0] r_buf_mdata [IN_FIFO_DEPTH];
  logic [BUF_PW-1:0]      r_buf_wr, r_buf_rd;
  logic [BUF_CW-1:0]      r_buf_cnt;
  logic                   r_almost_full, r_err_overflow;

  logic              w_buf_full, w_buf_enq, w_buf_pop;
  logic [BUF_PW-1:0] w_buf_wr_nxt, w_buf_rd_nxt;
  logic [BUF_CW-1:0] w_buf_cnt_d;

  assign w_buf_full   = (r_buf_cnt == BUF_CW'(IN_FIFO_DEPTH));
  assign w_buf_enq    = i_req_valid && !w_buf_full;
  assign w_buf_wr_nxt = (r_buf_wr == BUF_PW'(IN_FIFO_DEPTH - 1)) ? '0 : r_buf_wr + BUF_PW'(1);
  assign w_buf_rd_nxt = (r_buf_rd == BUF_PW'(IN_FIFO_DEPTH - 1)) ? '0 : r_buf_rd + BUF_PW'(1);
  assign w_buf_cnt_d  = r_buf_cnt + BUF_CW'(w_buf_enq) - BUF_CW'(w_buf_pop);

  always_ff @(posedge clk) begin
    if (w_buf_enq) begin
      r_buf_addr[r_buf_wr]  <= i_req_addr;
      r_buf_len[r_buf_wr]   <= i_req_len;
      r_buf_mdata[r_buf_wr] <= i_req_mdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_wr       <= '0;
      r_buf_rd       <= '0;
      r_buf_cnt      <= '0;
      r_almost_full  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_buf_enq) r_buf_wr <= w_buf_wr_nxt;
      if (w_buf_pop) r_buf_rd <= w_buf_rd_nxt;
      r_buf_cnt     <= w_buf_cnt_d;
      r_almost_full <= (32'(w_buf_cnt_d) >= AF_LEVEL);
      if (i_req_valid && w_buf_full) r_err_overflow <= 1'b1;
    end
  end

  // ---------------- splitter ----------------
  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic [LINES_W-1:0]     r_lines_left;
  logic [LEN_W-1:0]       r_len;
  logic [MDATA_WIDTH-1:0] r_mdata;
  logic                   r_first;
  logic                   r_avmm_read;
  logic [ADDR_WIDTH-1:0]  r_avmm_address;
  logic [BURST_W-1:0]     r_avmm_burstcount;
  logic [ACT_W-1:0]       r_active;

  logic                   w_accept, w_rdv_ok, w_credit_ok;
  logic [LINES_W-1:0]     w_rem_lines;
  logic [ADDR_WIDTH-1:0]  w_rem_addr;
  state_t                 w_state_d;
  logic [ADDR_WIDTH-1:0]  w_ctx_addr;
  logic [LINES_W-1:0]     w_ctx_lines;
  logic [LEN_W-1:0]       w_ctx_len;
  logic [MDATA_WIDTH-1:0] w_ctx_mdata;
  logic                   w_ctx_first;
  logic [BURST_W-1:0]     w_nburst;
  logic [ACT_W-1:0]       w_act_inc, w_active_d;
  logic [ACT_W-1:0]       r_trk_cnt;

  assign w_accept    = r_avmm_read && !i_avmm_waitrequest;
  assign w_rem_lines = r_lines_left - LINES_W'(r_avmm_burstcount);
  assign w_rem_addr  = r_cur_addr + ADDR_WIDTH'(r_avmm_burstcount);

  // Context describes the command to present next cycle: rest of this request, or the next one.
  always_comb begin
    w_state_d   = r_state;
    w_ctx_addr  = r_cur_addr;
    w_ctx_lines = r_lines_left;
    w_ctx_len   = r_len;
    w_ctx_mdata = r_mdata;
    w_ctx_first = r_first;
    w_buf_pop   = 1'b0;
    if (w_accept) begin
      w_ctx_first = 1'b0;
      if (w_rem_lines != '0) begin
        w_ctx_addr  = w_rem_addr;
        w_ctx_lines = w_rem_lines;
      end else begin
        w_buf_pop = 1'b1;
        if (r_buf_cnt > BUF_CW'(1)) begin
          w_state_d   = StIssue;
          w_ctx_addr  = r_buf_addr[w_buf_rd_nxt];
          w_ctx_len   = r_buf_len[w_buf_rd_nxt];
          w_ctx_lines = LINES_W'(r_buf_len[w_buf_rd_nxt]) + LINES_W'(1);
          w_ctx_mdata = r_buf_mdata[w_buf_rd_nxt];
          w_ctx_first = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
    end else if (r_state == StIdle && r_buf_cnt != '0) begin
      w_state_d   = StIssue;
      w_ctx_addr  = r_buf_addr[r_buf_rd];
      w_ctx_len   = r_buf_len[r_buf_rd];
      w_ctx_lines = LINES_W'(r_buf_len[r_buf_rd]) + LINES_W'(1);
      w_ctx_mdata = r_buf_mdata[r_buf_rd];
      w_ctx_first = 1'b1;
    end
  end

  assign w_nburst = (w_ctx_lines > LINES_W'(MAX_AVMM_BURST)) ? BURST_W'(MAX_AVMM_BURST)
                                                             : BURST_W'(w_ctx_lines);
  assign w_rdv_ok    = i_avmm_readdatavalid && (r_trk_cnt != '0);
  assign w_act_inc   = w_accept ? ACT_W'(r_avmm_burstcount) : '0;
  assign w_active_d  = r_active + w_act_inc - ACT_W'(w_rdv_ok);
  assign w_credit_ok = (32'(w_active_d) + 32'(w_nburst)) <= MAX_ACTIVE_LINES;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= StIdle;
      r_cur_addr        <= '0;
      r_lines_left      <= '0;
      r_len             <= '0;
      r_mdata           <= '0;
      r_first           <= 1'b0;
      r_avmm_read       <= 1'b0;
      r_avmm_address    <= '0;
      r_avmm_burstcount <= '0;
      r_active          <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cur_addr   <= w_ctx_addr;
      r_lines_left <= w_ctx_lines;
      r_len        <= w_ctx_len;
      r_mdata      <= w_ctx_mdata;
      r_first      <= w_ctx_first;
      r_active     <= w_active_d;
      if (r_avmm_read && i_avmm_waitrequest) begin
        r_avmm_read <= 1'b1;
      end else if (w_state_d == StIssue && w_credit_ok) begin
        r_avmm_read       <= 1'b1;
        r_avmm_address    <= w_ctx_addr;
        r_avmm_burstcount <= w_nburst;
      end else begin
        r_avmm_read <= 1'b0;
      end
    end
  end

  // ---------------- tracker and response ----------------
  logic [LEN_W-1:0]       r_trk_len   [MAX_ACTIVE_LINES];
  logic [MDATA_WIDTH-1:0] r_trk_mdata [MAX_ACTIVE_LINES];
  logic [TRK_PW-1:0]      r_trk_wr, r_trk_rd;
  logic [LEN_W-1:0]       r_cl_cnt;
  logic                   r_rsp_valid, r_rsp_last, r_err_underflow;
  logic [DATA_WIDTH-1:0]  r_rsp_data;
  logic [LEN_W-1:0]       r_rsp_cl_num;
  logic [MDATA_WIDTH-1:0] r_rsp_mdata;

  logic w_trk_enq, w_trk_last, w_trk_pop;

  assign w_trk_enq  = w_accept && r_first;
  assign w_trk_last = (r_cl_cnt == r_trk_len[r_trk_rd]);
  assign w_trk_pop  = w_rdv_ok && w_trk_last;

  always_ff @(posedge clk) begin
    if (w_trk_enq) begin
      r_trk_len[r_trk_wr]   <= r_len;
      r_trk_mdata[r_trk_wr] <= r_mdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trk_wr        <= '0;
      r_trk_rd        <= '0;
      r_trk_cnt       <= '0;
      r_cl_cnt        <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_cl_num    <= '0;
      r_rsp_mdata     <= '0;
      r_rsp_last      <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_trk_enq) begin
        r_trk_wr <= (r_trk_wr == TRK_PW'(MAX_ACTIVE_LINES - 1)) ? '0 : r_trk_wr + TRK_PW'(1);
      end
      if (w_trk_pop) begin
        r_trk_rd <= (r_trk_rd == TRK_PW'(MAX_ACTIVE_LINES - 1)) ? '0 : r_trk_rd + TRK_PW'(1);
      end
      r_trk_cnt   <= r_trk_cnt + ACT_W'(w_trk_enq) - ACT_W'(w_trk_pop);
      r_rsp_valid <= w_rdv_ok;
      if (w_rdv_ok) begin
        r_rsp_data   <= i_avmm_readdata;
        r_rsp_cl_num <= r_cl_cnt;
        r_rsp_mdata  <= r_trk_mdata[r_trk_rd];
        r_rsp_last   <= w_trk_last;
        r_cl_cnt     <= w_trk_last ? '0 : r_cl_cnt + LEN_W'(1);
      end
      if (i_avmm_readdatavalid && r_trk_cnt == '0) r_err_underflow <= 1'b1;
    end
  end

  assign o_req_almost_full = r_almost_full;
  assign o_avmm_read       = r_avmm_read;
  assign o_avmm_address    = r_avmm_address;
  assign o_avmm_burstcount = r_avmm_burstcount;
  assign o_rsp_valid       = r_rsp_valid;
  assign o_rsp_data        = r_rsp_data;
  assign o_rsp_cl_num      = r_rsp_cl_num;
  assign o_rsp_mdata       = r_rsp_mdata;
  assign o_rsp_last        = r_rsp_last;
  assign o_active_lines    = r_active;
  assign o_err_overflow    = r_err_overflow;
  assign o_err_underflow   = r_err_underflow;

endmodule
